// File: rtl/morse_key_decoder_pkg.sv
// Shared Morse definitions: FSM states, symbol values, default timing and the
// character lookup used by both the decoder and the trainer.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MARK  = 3'd1,
    SPACE = 3'd2,
    HOLD  = 3'd3,
    ERR   = 3'd4
  } morse_state_t;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned DEF_DOT_MIN  = 20;
  localparam int unsigned DEF_DASH_MIN = 60;
  localparam int unsigned DEF_CHAR_GAP = 40;
  localparam int unsigned DEF_MARK_MAX = 200;
  localparam int unsigned DEF_MAX_LEN  = 5;
  localparam int unsigned DEF_LEN_W    = $clog2(DEF_MAX_LEN + 1);

  typedef struct packed {
    logic [DEF_LEN_W-1:0]   len;
    logic [DEF_MAX_LEN-1:0] code;
  } morse_char_t;

  // First symbol sits in the MSB of the len-bit field; the newest in the LSB.
  function automatic morse_char_t morse_lookup(input logic [7:0] ch);
    morse_char_t r;
    r = '0;
    case (ch)
      "A": r = '{3'd2, 5'b00001};
      "B": r = '{3'd4, 5'b01000};
      "C": r = '{3'd4, 5'b01010};
      "D": r = '{3'd3, 5'b00100};
      "E": r = '{3'd1, 5'b00000};
      "F": r = '{3'd4, 5'b00010};
      "G": r = '{3'd3, 5'b00110};
      "H": r = '{3'd4, 5'b00000};
      "I": r = '{3'd2, 5'b00000};
      "J": r = '{3'd4, 5'b00111};
      "K": r = '{3'd3, 5'b00101};
      "L": r = '{3'd4, 5'b00100};
      "M": r = '{3'd2, 5'b00011};
      "N": r = '{3'd2, 5'b00010};
      "O": r = '{3'd3, 5'b00111};
      "P": r = '{3'd4, 5'b00110};
      "Q": r = '{3'd4, 5'b01101};
      "R": r = '{3'd3, 5'b00010};
      "S": r = '{3'd3, 5'b00000};
      "T": r = '{3'd1, 5'b00001};
      "U": r = '{3'd3, 5'b00001};
      "V": r = '{3'd4, 5'b00001};
      "W": r = '{3'd3, 5'b00011};
      "X": r = '{3'd4, 5'b01001};
      "Y": r = '{3'd4, 5'b01011};
      "Z": r = '{3'd4, 5'b01100};
      "0": r = '{3'd5, 5'b11111};
      "1": r = '{3'd5, 5'b01111};
      "2": r = '{3'd5, 5'b00111};
      "3": r = '{3'd5, 5'b00011};
      "4": r = '{3'd5, 5'b00001};
      "5": r = '{3'd5, 5'b00000};
      "6": r = '{3'd5, 5'b10000};
      "7": r = '{3'd5, 5'b11000};
      "8": r = '{3'd5, 5'b11100};
      "9": r = '{3'd5, 5'b11110};
      "/": r = '{3'd5, 5'b10010};
      "=": r = '{3'd5, 5'b10001};
      "+": r = '{3'd5, 5'b01010};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_key_decoder_sync.sv
// Two-flop synchroniser for the raw key line, with edge pulses derived from
// the synchronised level and its one-cycle-delayed copy.
module morse_key_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic key_s,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic key_s_q;
  logic key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      key_s_q <= 1'b0;
      key_q   <= 1'b0;
    end else begin
      meta_q  <= key;
      key_s_q <= meta_q;
      key_q   <= key_s_q;
    end
  end

  assign key_s = key_s_q;
  assign rise  = key_s_q & ~key_q;
  assign fall  = ~key_s_q & key_q;

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key decoder: times marks/spaces on a synchronised key, packs dots and
// dashes into a code word and offers {code, len} over valid/ready.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned DOT_MIN  = DEF_DOT_MIN,
  parameter int unsigned DASH_MIN = DEF_DASH_MIN,
  parameter int unsigned CHAR_GAP = DEF_CHAR_GAP,
  parameter int unsigned MARK_MAX = DEF_MARK_MAX,
  parameter int unsigned MAX_LEN  = DEF_MAX_LEN,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic               key_i,
  input  logic [MAX_LEN-1:0] target_code_i,
  input  logic [LEN_W-1:0]   target_len_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [MAX_LEN-1:0] code_o,
  output logic [LEN_W-1:0]   len_o,
  output logic               match_o,
  output logic               err_o,
  output logic               overrun_o
);

  localparam logic [CNT_W-1:0] DOT_MIN_C  = CNT_W'(DOT_MIN);
  localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] OVER_C     = CNT_W'(MARK_MAX + 1);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [LEN_W-1:0] FULL_C     = LEN_W'(MAX_LEN);

  logic key_s, key_rise, key_fall;

  morse_key_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_i),
    .key_s (key_s),
    .rise  (key_rise),
    .fall  (key_fall)
  );

  morse_state_t       state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d, timer_inc;
  logic [MAX_LEN-1:0] code_q, code_d, code_app;
  logic [LEN_W-1:0]   len_q, len_d, len_inc;
  logic               err_q, err_d, ovr_q, ovr_d;
  logic               sym;
  logic [MAX_LEN-1:0] len_mask;

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + ONE_C;
  assign sym       = (timer_q >= DASH_MIN_C) ? SYM_DASH : SYM_DOT;
  assign code_app  = {code_q[MAX_LEN-2:0], sym};
  assign len_inc   = len_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    code_d  = code_q;
    len_d   = len_q;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      timer_d = '0;
      code_d  = '0;
      len_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          code_d  = '0;
          len_d   = '0;
          if (key_rise) begin
            state_d = MARK;
            timer_d = ONE_C;
          end
        end
        MARK: begin
          // Over-length check wins over a coincident release.
          if (timer_q == OVER_C) begin
            state_d = ERR;
            err_d   = 1'b1;
            timer_d = '0;
            code_d  = '0;
            len_d   = '0;
          end else if (key_fall) begin
            if (timer_q < DOT_MIN_C) begin
              state_d = (len_q != '0) ? SPACE : IDLE;
              timer_d = (len_q != '0) ? ONE_C : '0;
            end else begin
              code_d = code_app;
              len_d  = len_inc;
              if (len_inc == FULL_C) begin
                state_d = HOLD;
                timer_d = '0;
              end else begin
                state_d = SPACE;
                timer_d = ONE_C;
              end
            end
          end else if (key_s) begin
            timer_d = timer_inc;
          end
        end
        SPACE: begin
          if (key_rise) begin
            state_d = MARK;
            timer_d = ONE_C;
          end else if (timer_q == GAP_C) begin
            state_d = HOLD;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        HOLD: begin
          ovr_d = key_rise;
          if (ready_i) begin
            state_d = IDLE;
            code_d  = '0;
            len_d   = '0;
          end
        end
        ERR: begin
          if (!key_s) begin
            state_d = IDLE;
            timer_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
          code_d  = '0;
          len_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      code_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      len_q   <= len_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    len_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign valid_o   = (state_q == HOLD);
  assign code_o    = code_q;
  assign len_o     = len_q;
  assign match_o   = valid_o && (len_q == target_len_i) &&
                     ((code_q & len_mask) == (target_code_i & len_mask));
  assign err_o     = err_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder: character table, target-match table
// and hand-written sequences for backpressure, error, reset and enable.
module tb_morse_key_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable_i = 1'b0;
  logic       key_i = 1'b0;
  logic       ready_i = 1'b0;
  logic [4:0] target_code_i = '0;
  logic [2:0] target_len_i = '0;
  logic       valid_o, match_o, err_o, overrun_o;
  logic [4:0] code_o;
  logic [2:0] len_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  morse_key_decoder #(
    .CNT_W    (8),
    .DOT_MIN  (20),
    .DASH_MIN (60),
    .CHAR_GAP (40),
    .MARK_MAX (200),
    .MAX_LEN  (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable_i      (enable_i),
    .key_i         (key_i),
    .target_code_i (target_code_i),
    .target_len_i  (target_len_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .code_o        (code_o),
    .len_o         (len_o),
    .match_o       (match_o),
    .err_o         (err_o),
    .overrun_o     (overrun_o)
  );

  typedef struct packed {
    logic [2:0] tl;
    logic [4:0] tc;
    logic       m;
  } tvec_t;

  typedef struct packed {
    logic [7:0] m0, m1, m2, m3, m4;
    logic [4:0] code;
    logic [2:0] len;
    logic [7:0] lat;
    logic [7:0] ch;
  } cvec_t;

  function automatic cvec_t mk(input int a, input int b, input int c, input int d,
                               input int e, input logic [4:0] code, input int len,
                               input int lat, input logic [7:0] ch);
    cvec_t v;
    v.m0 = 8'(a); v.m1 = 8'(b); v.m2 = 8'(c); v.m3 = 8'(d); v.m4 = 8'(e);
    v.code = code; v.len = 3'(len); v.lat = 8'(lat); v.ch = ch;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark(input int n);
    key_i = 1'b1;
    tick(n);
    key_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      tick(1);
      if (valid_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic handshake();
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
  endtask

  function automatic int is_idle();
    return int'(dut.state_q == morse_pkg::IDLE);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tvec_t mt[7];
    cvec_t cv[11];
    morse_pkg::morse_char_t mc;
    int lat, first, ne, nv, nov, bad;
    int mk_arr[5];

    mt[0] = '{3'd2, 5'b00001, 1'b1};
    mt[1] = '{3'd2, 5'b00010, 1'b0};
    mt[2] = '{3'd1, 5'b00001, 1'b0};
    mt[3] = '{3'd2, 5'b11101, 1'b1};
    mt[4] = '{3'd3, 5'b00001, 1'b0};
    mt[5] = '{3'd2, 5'b00011, 1'b0};
    mt[6] = '{3'd2, 5'b00000, 1'b0};

    cv[0]  = mk(25, 0, 0, 0, 0,    5'b00000, 1, 43, "E");
    cv[1]  = mk(70, 0, 0, 0, 0,    5'b00001, 1, 43, "T");
    cv[2]  = mk(5, 25, 0, 0, 0,    5'b00000, 1, 43, "E");
    cv[3]  = mk(19, 20, 0, 0, 0,   5'b00000, 1, 43, "E");
    cv[4]  = mk(59, 60, 0, 0, 0,   5'b00001, 2, 43, "A");
    cv[5]  = mk(200, 0, 0, 0, 0,   5'b00001, 1, 43, "T");
    cv[6]  = mk(60, 59, 59, 60, 0, 5'b01001, 4, 43, "X");
    cv[7]  = mk(70, 25, 70, 0, 0,  5'b00101, 3, 43, "K");
    cv[8]  = mk(25, 25, 25, 25, 25, 5'b00000, 5, 3, "5");
    cv[9]  = mk(70, 70, 70, 70, 70, 5'b11111, 5, 3, "0");
    cv[10] = mk(25, 70, 25, 70, 25, 5'b01010, 5, 3, "+");

    // Reset state
    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_code", int'(code_o), 0);
    chk("rst_len", int'(len_o), 0);
    chk("rst_match", int'(match_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);
    chk("rst_idle", is_idle(), 1);
    rst_n = 1'b1;
    enable_i = 1'b1;
    tick(2);

    // "A" and the target-match table while it is held
    mark(30);
    tick(10);
    mark(70);
    wait_valid(lat);
    chk("A_latency", lat, 43);
    chk("A_code", int'(code_o), 1);
    chk("A_len", int'(len_o), 2);
    for (int i = 0; i < 7; i++) begin
      target_len_i  = mt[i].tl;
      target_code_i = mt[i].tc;
      #1;
      chk($sformatf("match_vec%0d", i), int'(match_o), int'(mt[i].m));
    end
    handshake();
    chk("A_hs_valid", int'(valid_o), 0);
    chk("A_hs_code", int'(code_o), 0);
    chk("A_hs_len", int'(len_o), 0);

    // Character table
    for (int r = 0; r < 11; r++) begin
      mk_arr = '{int'(cv[r].m0), int'(cv[r].m1), int'(cv[r].m2), int'(cv[r].m3), int'(cv[r].m4)};
      for (int j = 0; j < 5; j++) begin
        if (mk_arr[j] != 0) begin
          if (j > 0) tick(10);
          mark(mk_arr[j]);
        end
      end
      wait_valid(lat);
      chk($sformatf("chr%0d_latency", r), lat, int'(cv[r].lat));
      chk($sformatf("chr%0d_code", r), int'(code_o), int'(cv[r].code));
      chk($sformatf("chr%0d_len", r), int'(len_o), int'(cv[r].len));
      mc = morse_pkg::morse_lookup(cv[r].ch);
      target_len_i  = mc.len;
      target_code_i = mc.code;
      #1;
      chk($sformatf("chr%0d_match", r), int'(match_o), 1);
      handshake();
      chk($sformatf("chr%0d_hs_valid", r), int'(valid_o), 0);
      tick(3);
    end

    // Backpressure with a press during HOLD
    mark(25);
    wait_valid(lat);
    chk("bp_latency", lat, 43);
    nov = 0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (k == 10) key_i = 1'b1;
      if (k == 40) key_i = 1'b0;
      tick(1);
      if (overrun_o) nov++;
      if (!valid_o || code_o != 5'd0 || len_o != 3'd1) bad++;
    end
    chk("bp_overrun_pulses", nov, 1);
    chk("bp_outputs_changed", bad, 0);
    handshake();
    chk("bp_hs_valid", int'(valid_o), 0);
    chk("bp_hs_idle", is_idle(), 1);

    // Key held across the handshake is not a new mark
    mark(25);
    wait_valid(lat);
    key_i = 1'b1;
    tick(5);
    handshake();
    tick(50);
    key_i = 1'b0;
    nv = 0;
    for (int k = 0; k < 60; k++) begin
      tick(1);
      if (valid_o) nv++;
    end
    chk("held_no_valid", nv, 0);
    chk("held_idle", is_idle(), 1);
    chk("held_len", int'(len_o), 0);

    // Over-length mark
    key_i = 1'b1;
    first = -1;
    ne = 0;
    nv = 0;
    for (int k = 1; k <= 250; k++) begin
      tick(1);
      if (err_o) begin
        ne++;
        if (first < 0) first = k;
      end
      if (valid_o) nv++;
    end
    key_i = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick(1);
      if (err_o) ne++;
      if (valid_o) nv++;
    end
    chk("err_first_cycle", first, 204);
    chk("err_pulses", ne, 1);
    chk("err_no_valid", nv, 0);
    chk("err_idle", is_idle(), 1);
    mark(70);
    wait_valid(lat);
    chk("err_T_latency", lat, 43);
    chk("err_T_code", int'(code_o), 1);
    chk("err_T_len", int'(len_o), 1);
    handshake();

    // Asynchronous reset in SPACE with two symbols
    mark(25);
    tick(10);
    mark(70);
    tick(10);
    chk("rstmid_len_before", int'(len_o), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_len", int'(len_o), 0);
    chk("rstmid_code", int'(code_o), 0);
    chk("rstmid_valid", int'(valid_o), 0);
    chk("rstmid_idle", is_idle(), 1);
    rst_n = 1'b1;
    tick(2);
    mark(25);
    wait_valid(lat);
    chk("rstmid_E_latency", lat, 43);
    chk("rstmid_E_len", int'(len_o), 1);
    chk("rstmid_E_code", int'(code_o), 0);
    handshake();

    // Enable dropped for one cycle during HOLD
    mark(70);
    wait_valid(lat);
    chk("en_valid_before", int'(valid_o), 1);
    enable_i = 1'b0;
    tick(1);
    enable_i = 1'b1;
    chk("en_valid", int'(valid_o), 0);
    chk("en_idle", is_idle(), 1);
    chk("en_len", int'(len_o), 0);
    chk("en_code", int'(code_o), 0);
    tick(5);
    chk("en_stays_low", int'(valid_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Parametrised Morse key decoder, the next generation of the trainer's input path. It samples a raw key line and classifies each mark as a dot, a dash or a glitch using programmable cycle thresholds. It packs up to `MAX_LEN` symbols into a code word and delivers `{code, len}` over a valid/ready handshake, with an on-the-fly match against a target code. It sits between the pad input and the trainer's scoring/display logic and supports letters, digits and punctuation.

## Interface
Parameters:
- `CNT_W`, 8: width of the duration timer; must hold `MARK_MAX+1`.
- `DOT_MIN`, 20: minimum mark cycles for a dot; shorter marks are glitches.
- `DASH_MIN`, 60: minimum mark cycles for a dash.
- `CHAR_GAP`, 40: space cycles that terminate a character.
- `MARK_MAX`, 200: longest legal mark; longer is an error.
- `MAX_LEN`, 5: maximum symbols per character. `LEN_W = $clog2(MAX_LEN+1)`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable_i` in 1: decoder enable; low forces IDLE and clears the code.
- `key_i` in 1: raw asynchronous key; 1 = key down.
- `target_code_i` in MAX_LEN: expected code; newest symbol in the LSB; 1 = dash.
- `target_len_i` in LEN_W: expected symbol count.
- `valid_o` out 1: character available.
- `ready_i` in 1: consumer accepts the character.
- `code_o` out MAX_LEN: decoded symbols. LSB is the newest symbol; unused upper bits are 0.
- `len_o` out LEN_W: symbol count, 1..MAX_LEN.
- `match_o` out 1: qualified by `valid_o`. High when `len_o==target_len_i` and the low `len_o` bits of code match the target.
- `err_o` out 1: one-cycle pulse when a mark exceeds `MARK_MAX`.
- `overrun_o` out 1: one-cycle pulse when a key press arrives while in HOLD.

## Operation
- `key_i` passes through a 2-FF synchroniser to give `key_s`, plus a registered copy `key_q`. A rise is `key_s & ~key_q`; a fall is `~key_s & key_q`.
- States:
  - IDLE: timer, code and len are 0. A rise goes to MARK with timer=1.
  - MARK: timer increments on each cycle `key_s`=1.
    - Timer reaching `MARK_MAX+1` goes to ERR, pulses `err_o` and discards code/len.
    - On a fall with timer = N:
      - N<DOT_MIN: glitch, no append. Go to SPACE if len>0, else IDLE.
      - DOT_MIN≤N<DASH_MIN: append 0.
      - N≥DASH_MIN: append 1.
    - Append is `code={code[MAX_LEN-2:0],sym}`, `len++`. If the new len==MAX_LEN go to HOLD, else go to SPACE with timer=1.
  - SPACE: timer increments while `key_s`=0. A rise goes to MARK with timer=1. Timer==CHAR_GAP goes to HOLD.
  - HOLD: `valid_o`=1; `code_o`, `len_o` and `match_o` are stable. `valid_o&ready_i` goes to IDLE and clears code/len. A rise while in HOLD pulses `overrun_o` and that press is ignored entirely.
  - ERR: wait until `key_s`=0, then go to IDLE.
- Timer saturates at all ones and never wraps.
- `enable_i`=0 in any state: next state is IDLE, code/len are cleared, `valid_o` drops and no pulses are produced.
- On leaving HOLD, a key already down is not treated as a new mark; IDLE waits for a fresh rise.
- `target_*` are sampled combinationally and may change during HOLD; `match_o` follows them.

## Timing
- Reset values: state IDLE; synchroniser 0; timer, code, len 0; `valid_o`, `match_o`, `err_o`, `overrun_o` all 0.
- Latency from `key_i` edge to the `key_s` edge is 2 cycles.
- Symbol append becomes visible in code/len on the cycle after the fall is detected.
- `valid_o` rises on the cycle after timer==CHAR_GAP in SPACE, or on the cycle after the append that fills MAX_LEN.
- `valid_o` may stay high indefinitely under backpressure. Outputs must not change until the handshake completes.
- The handshake cycle is the last cycle of `valid_o`. In the next cycle the state is IDLE, `valid_o`=0 and `code_o`/`len_o` are 0.
- `err_o` asserts on the cycle after timer reaches `MARK_MAX+1`.
- `rst_n` assertion mid-character clears everything immediately (asynchronous). The first post-reset rise is treated as a new character.

## Structure
- Package `morse_pkg` holds:
  - the state enum {IDLE, MARK, SPACE, HOLD, ERR};
  - symbol constants `SYM_DOT=0`, `SYM_DASH=1`;
  - default timing constants;
  - the letter→{len,code} lookup function shared with the trainer.
- Sub-module `morse_key_sync`: 2-FF synchroniser with registered rise/fall pulses, async active-low reset.

## Test plan
- "A" (defaults): mark 30, space 10, mark 70, space 40 → `valid_o` with `code_o`=5'b00001, `len_o`=2. With target {2, 5'b00001}, `match_o`=1; with target {2, 5'b00010}, `match_o`=0.
- Glitch: mark 5, then mark 25 and space 40 → `len_o`=1, `code_o`=0 ("E"); the glitch adds no symbol.
- Full length: five marks of 25 separated by spaces of 10 → `valid_o` on the cycle after the fifth append, `len_o`=5, `code_o`=0; no CHAR_GAP wait.
- Backpressure: `ready_i`=0 for 100 cycles with a 30-cycle press during HOLD → one `overrun_o` pulse, outputs unchanged. On `ready_i`=1, IDLE follows on the next cycle.
- Error: mark 250 → `err_o` pulse after 201 high cycles, `valid_o` stays 0. After release the block is in IDLE and decodes "T" (mark 70, space 40) correctly.
- Reset/enable: assert `rst_n`=0 mid-SPACE with len=2 → all outputs 0 immediately. `enable_i`=0 for 1 cycle in HOLD → `valid_o` drops and state is IDLE.
